// File: rtl/imm_gen_if.sv
// Handshake bundle between the IF/ID side, the immediate stage and the ID/EX side.
// slave is the stage's view; master is the surrounding pipeline's view.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ins;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_ins;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_ins, in_tag, out_ready,
    output in_ready, out_valid, out_ins, out_tag, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_ins, in_tag, out_ready,
    input  in_ready, out_valid, out_ins, out_tag, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: decodes the immediate of each accepted instruction
// and buffers it with the instruction, format and tag in a small FIFO.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  imm_gen_if.slave    bus,
  output logic [15:0] illegal_cnt
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_ISEXT = 3'd1;
  localparam logic [2:0] FMT_IZEXT = 3'd2;
  localparam logic [2:0] FMT_SHAMT = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_SB    = 3'd5;
  localparam logic [2:0] FMT_J     = 3'd6;

  logic [4:0]       opcode;
  logic [11:0]      imm12;
  logic [6:0]       imm7;
  logic [4:0]       imm5;
  logic [19:0]      imm20;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_illegal;

  logic [31:0]      mem_ins [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic [2:0]       mem_fmt [DEPTH];
  logic             mem_ill [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign opcode = bus.in_ins[4:0];
  assign imm12  = bus.in_ins[31:20];
  assign imm7   = bus.in_ins[31:25];
  assign imm5   = bus.in_ins[11:7];
  assign imm20  = bus.in_ins[31:12];

  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      5'b00010, 5'b01111, 5'b10100: begin
        dec_imm = XLEN'($signed(imm12));
        dec_fmt = FMT_ISEXT;
      end
      5'b00101, 5'b00111, 5'b01001: begin
        dec_imm = XLEN'(imm12);
        dec_fmt = FMT_IZEXT;
      end
      5'b01011, 5'b01101: begin
        dec_imm = XLEN'(bus.in_ins[20 +: SHAMT_W]);
        dec_fmt = FMT_SHAMT;
      end
      5'b01110: begin
        dec_imm = XLEN'($signed({imm20, 12'h000}));
        dec_fmt = FMT_U;
      end
      5'b10000, 5'b10001, 5'b10010: begin
        dec_imm = XLEN'($signed({imm7, imm5}));
        dec_fmt = FMT_SB;
      end
      5'b10011: begin
        // jal keeps the raw 20-bit field; the shift happens downstream
        dec_imm = XLEN'($signed(imm20));
        dec_fmt = FMT_J;
      end
      5'b00000, 5'b00001: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (push && dec_illegal && (illegal_cnt != 16'hFFFF)) begin
        illegal_cnt <= illegal_cnt + 16'd1;
      end
    end
  end

  // storage needs no reset: every read is gated by out_valid
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_ins[wr_ptr] <= bus.in_ins;
      mem_tag[wr_ptr] <= bus.in_tag;
      mem_imm[wr_ptr] <= dec_imm;
      mem_fmt[wr_ptr] <= dec_fmt;
      mem_ill[wr_ptr] <= dec_illegal;
    end
  end

  assign bus.out_ins     = bus.out_valid ? mem_ins[rd_ptr] : '0;
  assign bus.out_tag     = bus.out_valid ? mem_tag[rd_ptr] : '0;
  assign bus.out_imm     = bus.out_valid ? mem_imm[rd_ptr] : '0;
  assign bus.out_fmt     = bus.out_valid ? mem_fmt[rd_ptr] : 3'd0;
  assign bus.out_illegal = bus.out_valid ? mem_ill[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Drives identical traffic into an XLEN=32 and an XLEN=64 instance and checks both
// against one arithmetic reference model through a shared expected-entry queue.
module tb_imm_gen_stage;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] tag;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [31:0] in_tag;
  logic        out_ready;
  logic [15:0] cnt32;
  logic [15:0] cnt64;

  imm_gen_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.in_ins    = in_ins;
  assign bus32.in_tag    = in_tag;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_ins    = in_ins;
  assign bus64.in_tag    = in_tag;
  assign bus64.out_ready = out_ready;

  imm_gen_stage #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus32), .illegal_cnt(cnt32)
  );
  imm_gen_stage #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus64), .illegal_cnt(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];
  int          model_cnt = 0;
  logic        last_accept = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic longint sx(input longint val, input int w);
    longint half = longint'(1) << (w - 1);
    return (val >= half) ? val - (longint'(1) << w) : val;
  endfunction

  // Reference decode written as plain arithmetic on the field values
  function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint v;
    int     op;
    op  = int'(ins[4:0]);
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (op)
      2, 15, 20: begin v = sx(longint'(ins[31:20]), 12); fmt = 3'd1; end
      5, 7, 9:   begin v = longint'(ins[31:20]); fmt = 3'd2; end
      11, 13:    begin v = longint'(ins[25:20]) % ((xlen == 64) ? 64 : 32); fmt = 3'd3; end
      14:        begin v = sx(longint'(ins[31:12]) * 4096, 32); fmt = 3'd4; end
      16, 17, 18: begin v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); fmt = 3'd5; end
      19:        begin v = sx(longint'(ins[31:12]), 20); fmt = 3'd6; end
      0, 1:      begin v = 0; fmt = 3'd0; end
      default:   begin v = 0; ill = 1'b1; end
    endcase
    imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
  endfunction

  // Monitor / scoreboard: compares at the falling edge, then applies the coming edge to the model
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_valid;
    exp_t e;
    last_accept = 1'b0;
    if (rst) begin
      q.delete();
      model_cnt = 0;
    end else begin
      exp_ready = (q.size() != DEPTH);
      exp_valid = (q.size() != 0);
      chk("in_ready32", 64'(bus32.in_ready), 64'(exp_ready));
      chk("in_ready64", 64'(bus64.in_ready), 64'(exp_ready));
      chk("out_valid32", 64'(bus32.out_valid), 64'(exp_valid));
      chk("out_valid64", 64'(bus64.out_valid), 64'(exp_valid));
      chk("illegal_cnt32", 64'(cnt32), 64'(model_cnt));
      chk("illegal_cnt64", 64'(cnt64), 64'(model_cnt));
      if (exp_valid) begin
        e = q[0];
        chk("out_ins32", 64'(bus32.out_ins), 64'(e.ins));
        chk("out_tag32", 64'(bus32.out_tag), 64'(e.tag));
        chk("out_imm32", 64'(bus32.out_imm), e.imm32);
        chk("out_fmt32", 64'(bus32.out_fmt), 64'(e.fmt));
        chk("out_illegal32", 64'(bus32.out_illegal), 64'(e.ill));
        chk("out_ins64", 64'(bus64.out_ins), 64'(e.ins));
        chk("out_tag64", 64'(bus64.out_tag), 64'(e.tag));
        chk("out_imm64", bus64.out_imm, e.imm64);
        chk("out_fmt64", 64'(bus64.out_fmt), 64'(e.fmt));
        chk("out_illegal64", 64'(bus64.out_illegal), 64'(e.ill));
      end else begin
        chk("idle_data32", {bus32.out_ins, bus32.out_imm} | 64'(bus32.out_tag)
            | 64'(bus32.out_fmt) | 64'(bus32.out_illegal), 64'd0);
        chk("idle_data64", bus64.out_imm | 64'(bus64.out_ins) | 64'(bus64.out_tag)
            | 64'(bus64.out_fmt) | 64'(bus64.out_illegal), 64'd0);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          e.ins = in_ins;
          e.tag = in_tag;
          ref_dec(in_ins, 32, e.imm32, e.fmt, e.ill);
          ref_dec(in_ins, 64, e.imm64, e.fmt, e.ill);
          q.push_back(e);
          if (e.ill && model_cnt != 16'hFFFF) model_cnt++;
          last_accept = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] tag);
    bit done = 0;
    in_valid = 1'b1;
    in_ins   = ins;
    in_tag   = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (last_accept) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout tag=0x%0h: got no acceptance, expected acceptance within 50 cycles", tag);
    end
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_ins();
    return {$urandom_range(0, 32'h07FF_FFFF), 5'(0)} | 32'($urandom_range(0, 31));
  endfunction

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ins    = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    push(32'hFFF0_0002, 32'h100);
    push(32'hFFF0_0005, 32'h104);
    repeat (3) step();

    push(32'h1234_500E, 32'h108);
    push(32'h8000_0F90, 32'h10C);
    push(32'h8000_0013, 32'h110);
    push(32'h8000_000E, 32'h114);
    push(32'h03F0_000B, 32'h118);
    repeat (3) step();

    // back-pressure: third push waits for a pop
    out_ready = 1'b0;
    fork
      begin
        push(32'h0010_0002, 32'h200);
        push(32'h0020_0002, 32'h204);
        push(32'h0030_0002, 32'h208);
      end
      begin
        repeat (6) step();
        out_ready = 1'b1;
      end
    join
    repeat (4) step();

    // flush with a live illegal input in the same cycle
    out_ready = 1'b0;
    push(32'h0000_0022, 32'h300);
    push(32'h0000_0042, 32'h304);
    in_valid = 1'b1;
    in_ins   = 32'h0000_001F;
    in_tag   = 32'h308;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    push(32'h0000_001F, 32'h400);
    push(32'h0000_001F, 32'h404);
    push(32'h0000_001F, 32'h408);
    repeat (3) step();

    // asynchronous reset with occupied FIFO
    out_ready = 1'b0;
    push(32'hFFF0_0002, 32'h500);
    push(32'h0000_001F, 32'h504);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_out_valid32", 64'(bus32.out_valid), 64'd0);
    chk("async_out_valid64", 64'(bus64.out_valid), 64'd0);
    chk("async_out_imm32", 64'(bus32.out_imm), 64'd0);
    chk("async_out_imm64", bus64.out_imm, 64'd0);
    chk("async_out_ins32", 64'(bus32.out_ins), 64'd0);
    chk("async_out_tag64", 64'(bus64.out_tag), 64'd0);
    chk("async_cnt32", 64'(cnt32), 64'd0);
    chk("async_cnt64", 64'(cnt64), 64'd0);
    chk("async_in_ready32", 64'(bus32.in_ready), 64'd1);
    repeat (2) step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ins    = rand_ins();
      in_tag    = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage between IF/ID and ID/EX.
- Decodes the immediate from each accepted instruction, then buffers instruction, immediate, format and sideband tag in a small FIFO behind a valid/ready handshake.
- Supports XLEN 32 or 64 and flush on branch redirect.
- Counts illegal opcodes seen.

Parameters:
- XLEN, 32, datapath width of the immediate; 32 or 64 only.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- TAG_W, 32, width of the sideband tag (PC) carried with each instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  drop all buffered and incoming entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_ins  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_ins  out  32  head instruction.
- out_tag  out  TAG_W  head tag.
- out_imm  out  XLEN  head immediate.
- out_fmt  out  3  head format: 0 none, 1 I-sext, 2 I-zext, 3 shamt, 4 U, 5 S/B, 6 J.
- out_illegal  out  1  head opcode not in decode table.
- illegal_cnt  out  16  saturating count of accepted illegal instructions.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset: FIFO empty, pointers 0, in_ready=1, out_valid=0, illegal_cnt=0. Data outputs are 0.
- Data outputs are forced to 0 whenever out_valid=0.
- Decode fields: opcode=ins[4:0]. imm12=ins[31:20]. imm7=ins[31:25]. imm5=ins[11:7]. imm20=ins[31:12]. SHAMT_W=5 if XLEN=32, 6 if XLEN=64.
- Decode is combinational on in_ins; the result is written into the FIFO at acceptance.
- 00010 addi, 01111 lw, 10100 jalr: sext(imm12), fmt 1.
- 00101 andi, 00111 ori, 01001 xori: zext(imm12), fmt 2.
- 01011 slli, 01101 srli: zext(ins[20 +: SHAMT_W]), fmt 3.
- 01110 lui: sext({imm20,12'h000}), fmt 4.
- 10000 sw, 10001 blt, 10010 beq: sext({imm7,imm5}), fmt 5.
- 10011 jal: sext(imm20), unshifted, fmt 6.
- Any other opcode: imm=0, fmt 0.
- Illegal flag: out_illegal=1 for opcodes outside the table, except R-type 00000/00001, which are legal with fmt 0.
- Sign extension always replicates the field MSB up to XLEN.
- Handshake: accept when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready.
- Latency: entry accepted at edge k appears with out_valid=1 after edge k. There is no same-cycle bypass.
- Ordering: FIFO order preserved. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, in_ready=0, so no push occurs that cycle even if a pop does; in_ready rises the following cycle.
- Empty: pop is impossible because out_valid=0.
- flush=1 at an edge:
  - count and pointers go to 0, and out_valid=0 after the edge.
  - The input handshaking in that cycle is discarded.
  - Flush dominates push and pop.
  - illegal_cnt is not incremented for the discarded input.
  - in_ready is unaffected during the flush cycle.
- illegal_cnt: +1 on each accepted illegal instruction that is not flushed; saturates at 16'hFFFF. It is cleared only by rst.
- rst asserted mid-operation clears everything immediately, with no dependence on clk.

Test Plan:
- XLEN=32: push 0xFFF00002 (addi), then 0xFFF00005 (andi), out_ready=1 -> out_imm 0xFFFFFFFF fmt 1, then 0x00000FFF fmt 2, each one cycle after acceptance.
- XLEN=32: push 0x1234500E (lui), 0x80000F90 (sw), 0x80000013 (jal) -> 0x12345000, 0xFFFFF81F, 0xFFF80000 in order.
- XLEN=64: push 0x8000000E (lui) -> out_imm 0xFFFFFFFF80000000. Push 0x03F0000B (slli) -> 0x3F; same word at XLEN=32 -> 0x1F.
- DEPTH=2, out_ready=0: three back-to-back pushes -> in_ready low after the second; the third is accepted only after one pop. Order of tags preserved.
- Push 2 entries, then assert flush with in_valid=1 -> out_valid=0 next cycle. The flushed input never appears. illegal_cnt unchanged.
- Push 0x0000001F (illegal) three times -> out_illegal=1, fmt 0, imm 0, illegal_cnt=3. Assert rst asynchronously mid-stream -> all outputs 0 before the next clk edge.
